// File: rtl/cpu_pkg.sv
// Shared datapath constants for the 64-bit core: operand width and the
// iterative multiplier's state encoding and counter width.
package cpu_pkg;

  localparam int XLEN      = 64;
  localparam int MUL_CNT_W = 7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/adder64.sv
// Structural 64-bit ripple-carry adder: one full-adder cell per bit.
// Purely combinational; the carry ripples from bit 0 to cout.
module adder64
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cin,
  output logic [XLEN-1:0] sum,
  output logic            cout
);

  logic [XLEN:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < XLEN; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[XLEN];

endmodule

// File: rtl/mul64_iter.sv
// Iterative unsigned 64x64->128 shift-add multiplier, one adder64 step per clock.
// 65 cycles from accepted start to the one-cycle done pulse; start is ignored while busy.
module mul64_iter
  import cpu_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [1:0]         state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   psum;
  logic               pcarry;

  assign addend = acc[0] ? mcand : '0;

  adder64 u_adder (
    .a    (acc[2*WIDTH-1:WIDTH]),
    .b    (addend),
    .cin  (1'b0),
    .sum  (psum),
    .cout (pcarry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b};
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Carry lands in bit 127 after the shift, so nothing is dropped.
          acc <= {pcarry, psum, acc[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Decoded straight from the state register, so no input-to-output path.
  assign ready   = (state == ST_IDLE);
  assign done    = (state == ST_DONE);
  assign product = acc;

endmodule

// File: doc/mul64_iter.md
# mul64_iter

Iterative unsigned 64×64→128 shift-add multiplier for the single-cycle 64-bit CPU datapath. It consumes the structural ripple-carry `adder64` as its only arithmetic element: one add-and-shift per clock, 64 iterations per product. The unit sits beside the ALU and returns the full 128-bit product through a start/done handshake, so the core can issue MUL/MULHU and stall until `done`.

## Interface
- `WIDTH`, 64: operand width. Product is 2×WIDTH. Only 64 is supported, because `adder64` is fixed width.
- `CNT_W`, 7: iteration counter width. Must be at least clog2(WIDTH)+1.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a multiply. Sampled only when `ready`=1.
- `a`, input, 64: multiplicand. Captured on the accepted `start` edge.
- `b`, input, 64: multiplier. Captured on the accepted `start` edge.
- `ready`, output, 1: high in IDLE. An operation is accepted when `start`=1 and `ready`=1.
- `done`, output, 1: one-cycle pulse; the product is valid.
- `product`, output, 128: a×b. Held stable from `done` until the next accepted `start`.

## Operation
- States:
  - IDLE: `ready`=1.
  - RUN: iterating.
  - DONE: `done`=1 for exactly one cycle.
- Registers:
  - `mcand[63:0]`
  - `acc[127:0]`: hi half = partial sum, lo half = remaining multiplier bits.
  - `cnt[CNT_W-1:0]`
  - `state`
- IDLE→RUN when `start`=1:
  - `mcand`←a
  - `acc`←{64'h0, b}
  - `cnt`←0
- RUN step, every cycle:
  - Compute `{c, s}` = `adder64`(acc[127:64], acc[0] ? mcand : 64'h0, cin=0).
  - acc ← {c, s, acc[63:1]}, a 129-bit value shifted right by one and truncated to 128 bits.
  - cnt ← cnt+1.
- RUN→DONE on the step where cnt == WIDTH-1, i.e. after 64 steps.
- DONE→IDLE unconditionally, next cycle.
- Width rule: the adder's `cout` always becomes bit 127 after the shift. No carry is lost, and the result is the exact unsigned 128-bit product.
- `product` is driven directly from `acc`. It is meaningful only from the DONE cycle until the next accepted `start`; the value during RUN is don't-care.
- `start` while `ready`=0 (RUN or DONE) is ignored. It is not queued and does not disturb the operation in flight.
- `a` and `b` may change freely after acceptance.
- Reset values (asynchronous, any state, including mid-RUN):
  - state=IDLE, `acc`=0, `mcand`=0, `cnt`=0
  - `ready`=1, `done`=0, `product`=0
  - An interrupted operation is abandoned with no `done`.

## Timing
- Let E0 be the rising edge at which `start` is accepted.
- RUN steps occur on edges E1…E64.
- `done`=1 and `product` is valid in the cycle following E64 (between E64 and E65).
- `ready` returns to 1 after E65.
- Latency is 65 cycles from acceptance to `done`. Back-to-back issue interval is 66 cycles: a new `start` can be accepted at E66 at the earliest.
- `ready`, `done` and `product` are registered outputs with no combinational path from inputs.
- The critical path is the 64-bit ripple through `adder64` plus the operand mux. The CPU clock period budget already covers `adder64`, so no extra pipelining is added.

## Structure
- Shared package `cpu_pkg` holds:
  - the state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - XLEN=64
  - MUL_CNT_W=7
- Sub-module: exactly one instance of the existing `adder64` (ports `a`, `b`, `cin`, `sum`, `cout`), with `cin` tied to 0.
- The FSM, counter, and shift register live in `mul64_iter`.

## Test plan
- Identity: a=1, b=1 → `done` exactly 65 cycles after acceptance; product=128'h0…0001.
- Max × max: a=b=64'hFFFF_FFFF_FFFF_FFFF → product=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001. This exercises `cout` into bit 127.
- Mixed and zero operands:
  - a=64'h0123_4567_89AB_CDEF, b=64'h10 → product=128'h0000_0000_0000_0000_1234_5678_9ABC_DEF0.
  - a=64'h8000_0000_0000_0000, b=0 → product=0.
- Busy start ignored: hold `start`=1 with new a/b throughout RUN and DONE → first result is unaffected, `done` pulses once, and the second op is accepted only at E66.
- Reset mid-op: assert `rst` at step 30 → `ready`=1, `done`=0, product=0 immediately (asynchronous); no `done` follows; a fresh op afterwards (a=3, b=5) yields 128'hF.
- Randomized check: 200 random a/b pairs against the 128-bit reference `a*b` computed in the bench. `$fatal` on mismatch; print "PASS tb_mul64_iter" at the end.
